// File: rtl/clock_divider_ctrl.sv
// Programmable clock divider with IDLE/RUN/PAUSE control, a divisor write handshake,
// a registered tick pulse at each period end and a registered divided clock.
module clock_divider_ctrl #(
    parameter int unsigned WIDTH = 26
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    input  logic [WIDTH-1:0] cfg_div,
    output logic             cfg_ready,
    input  logic             start,
    input  logic             stop,
    output logic             tick,
    output logic             slow_clk,
    output logic             busy,
    output logic [WIDTH-1:0] count
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             tick_q, tick_d;
    logic             slow_q, slow_d;
    logic             go;
    logic             period_end;

    // stop dominates start whenever both are asserted
    assign go         = start && !stop;
    assign period_end = (count_q == div_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            div_q   <= '0;
            count_q <= '0;
            tick_q  <= 1'b0;
            slow_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            count_q <= count_d;
            tick_q  <= tick_d;
            slow_q  <= slow_d;
        end
    end

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        count_d = count_q;
        tick_d  = 1'b0;
        slow_d  = slow_q;
        case (state_q)
            IDLE: begin
                count_d = '0;
                if (cfg_valid) begin
                    div_d = cfg_div;
                end
                if (go) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                // a period end still completes on a stop edge; otherwise stop freezes count
                if (period_end) begin
                    count_d = '0;
                    tick_d  = 1'b1;
                    slow_d  = ~slow_q;
                end else if (!stop) begin
                    count_d = count_q + 1'b1;
                end
                if (stop) begin
                    state_d = PAUSE;
                end
            end
            PAUSE: begin
                if (stop) begin
                    state_d = IDLE;
                    count_d = '0;
                    slow_d  = 1'b0;
                end else if (start) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = IDLE;
                count_d = '0;
                slow_d  = 1'b0;
            end
        endcase
    end

    assign cfg_ready = (state_q == IDLE);
    assign busy      = (state_q == RUN);
    assign tick      = tick_q;
    assign slow_clk  = slow_q;
    assign count     = count_q;

endmodule

// File: tb/tb_clock_divider_ctrl.sv
// Directed plus randomized bench for clock_divider_ctrl, checking a 26-bit and a 4-bit
// instance in lockstep against a behavioural model of the divider.
module tb_clock_divider_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cfg_valid = 1'b0;
    logic [25:0] cfg_div = '0;
    logic        start = 1'b0;
    logic        stop = 1'b0;

    logic        cfg_ready, tick, slow_clk, busy;
    logic [25:0] count;
    logic        cfg_ready4, tick4, slow_clk4, busy4;
    logic [3:0]  count4;
    logic [3:0]  cfg_div4;

    int unsigned tests = 0;
    int unsigned fails = 0;

    // model: mode 0 = idle, 1 = running, 2 = paused; index 0 = 26-bit, 1 = 4-bit
    int              m_mode [2];
    longint unsigned m_div  [2];
    longint unsigned m_pos  [2];
    bit              m_tick [2];
    bit              m_slow [2];
    longint unsigned mask   [2];

    assign cfg_div4 = cfg_div[3:0];

    clock_divider_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .cfg_valid(cfg_valid),
        .cfg_div  (cfg_div),
        .cfg_ready(cfg_ready),
        .start    (start),
        .stop     (stop),
        .tick     (tick),
        .slow_clk (slow_clk),
        .busy     (busy),
        .count    (count)
    );

    clock_divider_ctrl #(.WIDTH(4)) dut4 (
        .clk      (clk),
        .rst      (rst),
        .cfg_valid(cfg_valid),
        .cfg_div  (cfg_div4),
        .cfg_ready(cfg_ready4),
        .start    (start),
        .stop     (stop),
        .tick     (tick4),
        .slow_clk (slow_clk4),
        .busy     (busy4),
        .count    (count4)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_step(input int k);
        if (rst) begin
            m_mode[k] = 0;
            m_div[k]  = 0;
            m_pos[k]  = 0;
            m_tick[k] = 0;
            m_slow[k] = 0;
        end else begin
            case (m_mode[k])
                0: begin
                    m_tick[k] = 0;
                    m_pos[k]  = 0;
                    if (cfg_valid) m_div[k] = longint'(cfg_div) & mask[k];
                    if (start && !stop) m_mode[k] = 1;
                end
                1: begin
                    if (m_pos[k] == m_div[k]) begin
                        m_pos[k]  = 0;
                        m_tick[k] = 1;
                        m_slow[k] = !m_slow[k];
                    end else begin
                        m_tick[k] = 0;
                        if (!stop) m_pos[k] = m_pos[k] + 1;
                    end
                    if (stop) m_mode[k] = 2;
                end
                default: begin
                    m_tick[k] = 0;
                    if (stop) begin
                        m_mode[k] = 0;
                        m_pos[k]  = 0;
                        m_slow[k] = 0;
                    end else if (start) begin
                        m_mode[k] = 1;
                    end
                end
            endcase
        end
    endtask

    task automatic check_all();
        chk("tick",       64'(tick),       64'(m_tick[0]));
        chk("slow_clk",   64'(slow_clk),   64'(m_slow[0]));
        chk("busy",       64'(busy),       64'(m_mode[0] == 1));
        chk("cfg_ready",  64'(cfg_ready),  64'(m_mode[0] == 0));
        chk("count",      64'(count),      m_pos[0]);
        chk("tick4",      64'(tick4),      64'(m_tick[1]));
        chk("slow_clk4",  64'(slow_clk4),  64'(m_slow[1]));
        chk("busy4",      64'(busy4),      64'(m_mode[1] == 1));
        chk("cfg_ready4", 64'(cfg_ready4), 64'(m_mode[1] == 0));
        chk("count4",     64'(count4),     m_pos[1]);
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        check_all();
    endtask

    initial begin
        bit reached;
        mask[0] = 64'h3FF_FFFF;
        mask[1] = 64'hF;
        for (int k = 0; k < 2; k++) begin
            m_mode[k] = 0; m_div[k] = 0; m_pos[k] = 0; m_tick[k] = 0; m_slow[k] = 0;
        end

        // reset state
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        chk("rst_cfg_ready", 64'(cfg_ready), 64'd1);
        chk("rst_busy",      64'(busy),      64'd0);
        chk("rst_count",     64'(count),     64'd0);

        // divide by 4: handshake then start
        cfg_valid = 1'b1; cfg_div = 26'd3;
        cyc();
        cfg_valid = 1'b0; start = 1'b1;
        cyc();
        start = 1'b0;
        chk("d3_count0", 64'(count), 64'd0);
        for (int i = 1; i <= 12; i++) begin
            cyc();
            chk("d3_count_seq", 64'(count), 64'(i % 4));
            chk("d3_tick_seq",  64'(tick),  64'((i % 4) == 0));
        end

        // stop on the very edge that ends a period
        reached = 0;
        for (int i = 0; i < 8 && !reached; i++) begin
            if (m_pos[0] == 3) reached = 1;
            else cyc();
        end
        chk("wait_period_end", 64'(reached), 64'd1);
        stop = 1'b1;
        cyc();
        chk("stop_end_tick", 64'(tick), 64'd1);
        chk("stop_end_busy", 64'(busy), 64'd0);
        cyc();
        stop = 1'b0;
        chk("pause_stop_count", 64'(count),     64'd0);
        chk("pause_stop_slow",  64'(slow_clk),  64'd0);
        chk("pause_stop_ready", 64'(cfg_ready), 64'd1);

        // start and stop together in idle stays idle
        start = 1'b1; stop = 1'b1;
        cyc();
        start = 1'b0; stop = 1'b0;
        chk("both_idle_busy", 64'(busy), 64'd0);

        // divide by 1 with handshake coinciding with start
        cfg_valid = 1'b1; cfg_div = 26'd0; start = 1'b1;
        cyc();
        cfg_valid = 1'b0; start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cyc();
            chk("d0_tick", 64'(tick), 64'd1);
        end
        cfg_valid = 1'b1; cfg_div = 26'd5;
        chk("run_cfg_ready", 64'(cfg_ready), 64'd0);
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("d0_tick_after_cfg", 64'(tick), 64'd1);
        end
        cfg_valid = 1'b0;
        stop = 1'b1;
        cyc();
        cyc();
        stop = 1'b0;

        // pause mid-period and resume with no lost cycle
        cfg_valid = 1'b1; cfg_div = 26'd9;
        cyc();
        cfg_valid = 1'b0; start = 1'b1;
        cyc();
        start = 1'b0;
        for (int i = 0; i < 4; i++) cyc();
        chk("pre_pause_count", 64'(count), 64'd4);
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        chk("paused_count", 64'(count), 64'd4);
        chk("paused_busy",  64'(busy),  64'd0);
        for (int i = 0; i < 10; i++) cyc();
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("resume_count", 64'(count), 64'd4);
        chk("resume_busy",  64'(busy),  64'd1);
        for (int i = 1; i <= 6; i++) begin
            cyc();
            chk("resume_tick", 64'(tick), 64'(i == 6));
        end
        stop = 1'b1;
        cyc();
        cyc();
        stop = 1'b0;

        // full-range divisor on the 4-bit instance
        cfg_valid = 1'b1; cfg_div = 26'd15; start = 1'b1;
        cyc();
        cfg_valid = 1'b0; start = 1'b0;
        for (int i = 1; i <= 34; i++) begin
            cyc();
            chk("w4_count", 64'(count4), 64'(i % 16));
            chk("w4_tick",  64'(tick4),  64'((i % 16) == 0));
        end
        stop = 1'b1;
        cyc();
        cyc();
        stop = 1'b0;

        // reset mid-run, mid-handshake
        cfg_valid = 1'b1; cfg_div = 26'd5; start = 1'b1;
        cyc();
        cfg_valid = 1'b0; start = 1'b0;
        cyc();
        cyc();
        chk("pre_rst_count", 64'(count), 64'd2);
        rst = 1'b1; cfg_valid = 1'b1; cfg_div = 26'd7; start = 1'b1;
        cyc();
        rst = 1'b0; cfg_valid = 1'b0; start = 1'b0;
        chk("rst_run_busy",  64'(busy),     64'd0);
        chk("rst_run_count", 64'(count),    64'd0);
        chk("rst_run_tick",  64'(tick),     64'd0);
        chk("rst_run_slow",  64'(slow_clk), 64'd0);
        start = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
        chk("rst_div_zero_tick", 64'(tick), 64'd1);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            rst       = ($urandom_range(0, 59) == 0);
            cfg_valid = ($urandom_range(0, 3) == 0);
            cfg_div   = ($urandom_range(0, 9) == 0) ? 26'h3FF_FFFF : 26'($urandom_range(0, 20));
            start     = ($urandom_range(0, 5) == 0);
            stop      = ($urandom_range(0, 11) == 0);
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/clock_divider_ctrl.md
CLOCK_DIVIDER_CTRL -- requirements
Module: clock_divider_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 26, the width of the divide register and the counter.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port cfg_valid  input  1  divisor write request.
REQ-005 SHALL have port cfg_div  input  WIDTH  divisor value N; the tick period is N+1 cycles.
REQ-006 SHALL have port cfg_ready  output  1  divisor write accepted this cycle when high together with cfg_valid.
REQ-007 SHALL have port start  input  1  level-sampled start/resume command.
REQ-008 SHALL have port stop  input  1  level-sampled pause/halt command.
REQ-009 SHALL have port tick  output  1  registered one-cycle pulse at each period end.
REQ-010 SHALL have port slow_clk  output  1  registered divided clock; toggles on every tick.
REQ-011 SHALL have port busy  output  1  high only in state RUN.
REQ-012 SHALL have port count  output  WIDTH  current counter value, for observation.

Function
REQ-013 SHALL implement three states: IDLE, RUN, PAUSE.
REQ-014 SHALL hold divisor register div_q; cfg_ready SHALL be 1 in IDLE and 0 in RUN and PAUSE.
REQ-015 SHALL load div_q <= cfg_div on an edge with cfg_valid && cfg_ready; cfg_valid outside IDLE SHALL stall with no effect.
REQ-016 IDLE: start && !stop -> RUN, count <= 0; otherwise remain in IDLE with count held at 0.
REQ-017 RUN: count increments by 1 per cycle; on an edge with count == div_q, count <= 0, tick <= 1, slow_clk <= ~slow_clk.
REQ-018 RUN: tick SHALL be 0 on every edge where count != div_q; period is exactly div_q+1 cycles, slow_clk period 2*(div_q+1).
REQ-019 div_q == 0 SHALL give tick high every RUN cycle and slow_clk toggling every cycle.
REQ-020 div_q == all-ones SHALL count to 2^WIDTH-1 and wrap to 0 with a tick; count SHALL never exceed div_q.
REQ-021 RUN: stop -> PAUSE; count and slow_clk frozen; tick <= 0; start in RUN ignored.
REQ-022 PAUSE: start && !stop -> RUN, resuming from the frozen count with no extra or lost cycle.
REQ-023 PAUSE: stop -> IDLE, count <= 0, slow_clk <= 0, tick <= 0.
REQ-024 start and stop high together SHALL be treated as stop only.
REQ-025 In IDLE, a cfg handshake coinciding with start SHALL make the first RUN period use the new cfg_div.
REQ-026 A stop on the same edge as a period end SHALL not suppress that edge's tick/slow_clk update; transition to PAUSE also occurs.

Reset
REQ-027 On rst high at a clock edge: state <= IDLE, div_q <= 0, count <= 0, tick <= 0, slow_clk <= 0; busy = 0, cfg_ready = 1 the next cycle.
REQ-028 rst SHALL take priority over all other inputs, including mid-RUN and mid-handshake; no tick SHALL follow a reset edge.

Verification
REQ-029 Reset, cfg_div=3 handshake, start -> tick high every 4th cycle, slow_clk period 8 cycles, count sequence 0,1,2,3,0.
REQ-030 cfg_div=0, start -> tick constantly 1, slow_clk toggles every cycle; cfg_valid in RUN with cfg_div=5 -> cfg_ready=0, period unchanged.
REQ-031 cfg_div=9, run to count=4, stop 1 cycle, wait 10, start -> count resumes at 4, next tick exactly 6 cycles after resume.
REQ-032 PAUSE then stop -> IDLE, count=0, slow_clk=0, busy=0, cfg_ready=1; start and stop together in IDLE -> stays IDLE.
REQ-033 WIDTH=4, cfg_div=15 -> count reaches 15 and wraps to 0 with tick, period 16 cycles.
REQ-034 rst asserted at count=2 in RUN -> next cycle IDLE, count=0, tick=0, slow_clk=0, div_q=0.
